// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
// Holds word/address widths, the reset fetch address, the NOP encoding and
// the queue entry layout carried from memory response to decode.
package instruction_fetch_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 33;
  localparam int unsigned PC_WIDTH          = 16;
  localparam int unsigned BUF_DEPTH         = 2;

  localparam logic [PC_WIDTH-1:0]          RESET_PC  = '0;
  localparam logic [INSTRUCTION_WIDTH-1:0] INSTR_NOP = '0;

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]          pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc} between the memory response and decode.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push        write push_entry at the tail
//   push_entry  entry to write
//   pop         retire the head entry (caller guarantees count != 0)
//   flush       empty the queue; wins over push, pop is irrelevant then
//   count       number of valid entries (0..2)
//   head        oldest entry; only meaningful when count != 0
module fetch_buffer
  import instruction_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [BUF_DEPTH];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction memory, buffers returned words in a 2-entry
// queue and hands them to decode over a valid/ready handshake. A branch
// redirect flushes the queue, kills the in-flight read and reloads the PC.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   imem_en          read strobe; data returns on imem_rdata next cycle
//   imem_addr        word address of the read (current PC)
//   imem_rdata       read data for the previous cycle's strobe
//   instr, instr_pc  head instruction and its address (zero when invalid)
//   instr_valid      head entry present
//   instr_ready      decode accepts the head this cycle
//   redirect_valid   taken branch; flushes and reloads PC
//   redirect_target  absolute next fetch address
//   halt             suppresses new reads, in-flight read still lands
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_en,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_target,
  input  logic                         halt
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] inflight_pc_q;
  logic                inflight_q;
  logic                run_q;
  logic [1:0]          count;
  logic [2:0]          occupancy;
  logic                pop;
  logic                push;
  logic                issue;
  fetch_entry_t        head;
  fetch_entry_t        push_entry;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready;

  // A returning word is always pushed; a same-cycle redirect drives flush,
  // which takes priority inside the buffer and so discards the killed read.
  assign push             = inflight_q;
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = inflight_pc_q;

  // Credit check: entries held plus the read in flight, less the entry
  // leaving this cycle, must leave room for the word being requested.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

  // run_q holds off issue for the first cycle after reset release so the
  // strobe stays low throughout reset and releases synchronously.
  assign issue = run_q & ~halt & ~redirect_valid
               & (occupancy < 3'(BUF_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = pc_q;

  assign instr    = instr_valid ? head.instr : INSTR_NOP;
  assign instr_pc = instr_valid ? head.pc    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      run_q         <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
      if (redirect_valid) begin
        pc_q <= redirect_target;
      end else if (issue) begin
        pc_q <= pc_q + 1'b1;
      end
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Memory word k holds 0x100 + k.
// Inputs change 1 time unit after the rising edge; outputs are sampled after
// a further settle step.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [32:0] imem_rdata;
  logic [32:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halt;

  int unsigned checks;
  int unsigned errors;

  instruction_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] word(input logic [15:0] pc);
    return 33'h100 + {17'b0, pc};
  endfunction

  // Synchronous memory model; returns junk when no read was strobed.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? word(imem_addr) : 33'h1_dead_beef;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, instr_valid, 1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, word(pc));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_pc"}, instr_pc, 0);
  endtask

  // Writing into a full queue without a pop or flush would overflow it.
  always @(negedge clk) begin
    if (rst_n) begin
      check("no_overflow",
            dut.push & ~dut.redirect_valid & ~dut.pop & (dut.count == 2'd2), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    halt            = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_en", imem_en, 0);
    expect_empty("rst");

    // Release; cycle 0 issues nothing, cycle 1 issues pc 0
    rst_n = 1'b1;
    settle();
    check("c0_en", imem_en, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("fill_en", imem_en, 1);
      check("fill_addr", imem_addr, 16'(c - 1));
      if (c >= 3) expect_head("fill", 16'(c - 3));
      else        expect_empty("fill");
    end

    // Backpressure for 4 cycles with pc 2 at the head
    instr_ready = 1'b0;
    settle();
    check("bp_en", imem_en, 0);
    expect_head("bp", 16'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_en", imem_en, 0);
      expect_head("bp", 16'd2);
    end
    tick();
    instr_ready = 1'b1;
    settle();
    expect_head("bp_rel", 16'd2);
    check("bp_rel_en", imem_en, 1);
    check("bp_rel_addr", imem_addr, 16'd4);
    for (int p = 3; p <= 6; p++) begin
      tick();
      expect_head("bp_after", 16'(p));
    end

    // Redirect to 0x0040 while pc 7 is in flight; pc 6 pop is honoured
    redirect_valid  = 1'b1;
    redirect_target = 16'h0040;
    settle();
    check("rd1_en", imem_en, 0);
    expect_head("rd1_pop", 16'd6);
    tick();
    redirect_valid = 1'b0;
    settle();
    expect_empty("rd1_gap1");
    check("rd1_en1", imem_en, 1);
    check("rd1_addr1", imem_addr, 16'h0040);
    tick();
    expect_empty("rd1_gap2");
    check("rd1_addr2", imem_addr, 16'h0041);
    tick();
    expect_head("rd1_t0", 16'h0040);
    tick();
    expect_head("rd1_t1", 16'h0041);

    // Build a full queue {5, 6}, then redirect in the cycle pc 5 is popped
    redirect_valid  = 1'b1;
    redirect_target = 16'd5;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    check("rd2_addr5", imem_addr, 16'd5);
    tick();
    check("rd2_addr6", imem_addr, 16'd6);
    tick();
    expect_head("rd2_h5", 16'd5);
    instr_ready = 1'b0;
    settle();
    check("rd2_full_en", imem_en, 0);
    tick();
    expect_head("rd2_full", 16'd5);
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0123;
    settle();
    expect_head("rd2_pop5", 16'd5);
    check("rd2_en", imem_en, 0);
    tick();
    redirect_valid = 1'b0;
    settle();
    expect_empty("rd2_gap1");
    check("rd2_addr_t", imem_addr, 16'h0123);
    tick();
    expect_empty("rd2_gap2");
    tick();
    expect_head("rd2_t0", 16'h0123);
    tick();
    expect_head("rd2_t1", 16'h0124);

    // PC wrap
    redirect_valid  = 1'b1;
    redirect_target = 16'hFFFF;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    check("wrap_addr0", imem_addr, 16'hFFFF);
    tick();
    check("wrap_addr1", imem_addr, 16'h0000);
    tick();
    expect_head("wrap_ffff", 16'hFFFF);
    tick();
    expect_head("wrap_0000", 16'h0000);
    tick();
    expect_head("wrap_0001", 16'h0001);

    // Halt for 3 cycles: in-flight pc 2 lands, then resume at pc 3
    halt = 1'b1;
    settle();
    check("halt_en0", imem_en, 0);
    tick();
    check("halt_en1", imem_en, 0);
    expect_head("halt_land", 16'd2);
    tick();
    check("halt_en2", imem_en, 0);
    expect_empty("halt_drain");
    tick();
    halt = 1'b0;
    settle();
    check("resume_en", imem_en, 1);
    check("resume_addr", imem_addr, 16'd3);
    tick();
    expect_empty("resume_gap");
    tick();
    expect_head("resume_h", 16'd3);

    // Redirect while halted: PC reloads, issue waits for halt release
    halt            = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0200;
    settle();
    check("hr_en0", imem_en, 0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("hr_en1", imem_en, 0);
    check("hr_addr", imem_addr, 16'h0200);
    expect_empty("hr_flush");
    tick();
    check("hr_en2", imem_en, 0);
    halt = 1'b0;
    settle();
    check("hr_en3", imem_en, 1);
    check("hr_addr3", imem_addr, 16'h0200);
    tick();
    expect_empty("hr_gap");
    tick();
    expect_head("hr_t0", 16'h0200);

    // Reset pulse mid-stream: outputs clear without a clock edge
    rst_n = 1'b0;
    settle();
    check("rst2_en", imem_en, 0);
    expect_empty("rst2");
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    check("rst2_c0_en", imem_en, 0);
    tick();
    check("rst2_en1", imem_en, 1);
    check("rst2_addr0", imem_addr, 16'd0);
    tick();
    check("rst2_addr1", imem_addr, 16'd1);
    expect_empty("rst2_gap");
    tick();
    expect_head("rst2_h0", 16'd0);
    tick();
    expect_head("rst2_h1", 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
